// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: memory FSM encoding and
// the DEPTH legality check used at elaboration.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WRITE = 2'd1,
    M_READ  = 2'd2
  } mem_state_t;

  localparam int SB_DEFAULT_DEPTH = 4;
  localparam int SB_MIN_DEPTH     = 2;

  function automatic bit depth_ok(input int depth);
    return (depth >= SB_MIN_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Wishbone-style classic bus used on both sides of the store buffer.
interface wishbone #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] adr;
  logic [XLEN-1:0] dat_w;
  logic [XLEN-1:0] dat_r;
  logic            we;
  logic            stb;
  logic            cyc;
  logic            ack;

  modport MASTER (output adr, dat_w, we, stb, cyc, input dat_r, ack);
  modport SLAVE  (input adr, dat_w, we, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/store_buffer_fifo.sv
// Circular entry store for buffered writes; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate flag.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = SB_DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [XLEN-1:0]       i_adr,
  input  logic [XLEN-1:0]       i_dat,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic [PW-1:0]         o_count,
  output logic [AW-1:0]         o_rd_idx,
  output logic [XLEN-1:0]       o_head_adr,
  output logic [XLEN-1:0]       o_head_dat,
  output logic [DEPTH*XLEN-1:0] o_ent_adr,
  output logic [DEPTH*XLEN-1:0] o_ent_dat,
  output logic [DEPTH-1:0]      o_ent_valid
);

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [XLEN-1:0] r_adr [DEPTH];
  logic [XLEN-1:0] r_dat [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_adr[r_wr_ptr[AW-1:0]] <= i_adr;
      r_dat[r_wr_ptr[AW-1:0]] <= i_dat;
    end
  end

  assign o_count    = r_wr_ptr - r_rd_ptr;
  assign o_full     = (o_count == PW'(DEPTH));
  assign o_rd_idx   = r_rd_ptr[AW-1:0];
  assign o_head_adr = r_adr[r_rd_ptr[AW-1:0]];
  assign o_head_dat = r_dat[r_rd_ptr[AW-1:0]];

  // An entry is live when its distance from the read pointer is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [AW-1:0] w_off;
    assign w_off                       = AW'(gi) - r_rd_ptr[AW-1:0];
    assign o_ent_valid[gi]             = ({1'b0, w_off} < o_count);
    assign o_ent_adr[gi*XLEN +: XLEN]  = r_adr[gi];
    assign o_ent_dat[gi*XLEN +: XLEN]  = r_dat[gi];
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the load-store unit and data memory: queues stores,
// forwards loads from buffered data, and drains to memory in program order.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = SB_DEFAULT_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  wishbone.SLAVE   cpu_bus,
  wishbone.MASTER  mem_bus,
  output logic     empty
);

  localparam int AW       = $clog2(DEPTH);
  localparam int PW       = AW + 1;
  localparam bit DEPTH_OK = depth_ok(DEPTH);

  if (!DEPTH_OK) begin : g_depth_chk
    $error("store_buffer: DEPTH must be a power of two, at least 2");
  end

  mem_state_t      r_state;
  logic            r_mem_cyc;
  logic            r_mem_we;
  logic            r_cpu_ack;
  logic [XLEN-1:0] r_cpu_dat;

  logic                  w_req, w_store, w_load, w_push, w_pop, w_full;
  logic [PW-1:0]         w_count;
  logic [AW-1:0]         w_rd_idx;
  logic [XLEN-1:0]       w_head_adr, w_head_dat;
  logic [DEPTH*XLEN-1:0] w_ent_adr, w_ent_dat;
  logic [DEPTH-1:0]      w_ent_valid;
  logic                  w_hit;
  logic [XLEN-1:0]       w_hit_dat;
  logic [AW-1:0]         w_age, w_best_age;

  // Requests are ignored while ACK is up so each request is answered once.
  assign w_req   = cpu_bus.cyc & cpu_bus.stb & ~r_cpu_ack;
  assign w_store = w_req & cpu_bus.we;
  assign w_load  = w_req & ~cpu_bus.we;
  assign w_push  = w_store & ~w_full;
  assign w_pop   = (r_state == M_WRITE) & mem_bus.ack;

  sb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_adr       (cpu_bus.adr),
    .i_dat       (cpu_bus.dat_w),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_count     (w_count),
    .o_rd_idx    (w_rd_idx),
    .o_head_adr  (w_head_adr),
    .o_head_dat  (w_head_dat),
    .o_ent_adr   (w_ent_adr),
    .o_ent_dat   (w_ent_dat),
    .o_ent_valid (w_ent_valid)
  );

  // Youngest match = largest age relative to the read pointer, wrap-safe.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_dat  = '0;
    w_best_age = '0;
    w_age      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_age = AW'(i) - w_rd_idx;
      if (w_ent_valid[i] && (w_ent_adr[i*XLEN +: XLEN] == cpu_bus.adr) &&
          (!w_hit || (w_age >= w_best_age))) begin
        w_hit      = 1'b1;
        w_best_age = w_age;
        w_hit_dat  = w_ent_dat[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= M_IDLE;
      r_mem_cyc <= 1'b0;
      r_mem_we  <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_cpu_dat <= '0;
    end else begin
      r_cpu_ack <= w_push;
      if (w_load && w_hit) begin
        r_cpu_ack <= 1'b1;
        r_cpu_dat <= w_hit_dat;
      end
      case (r_state)
        M_IDLE: begin
          if (w_count != '0) begin
            r_state   <= M_WRITE;
            r_mem_cyc <= 1'b1;
            r_mem_we  <= 1'b1;
          end else if (w_load && !w_hit) begin
            r_state   <= M_READ;
            r_mem_cyc <= 1'b1;
            r_mem_we  <= 1'b0;
          end
        end
        M_WRITE: begin
          if (mem_bus.ack && (w_count <= PW'(1))) begin
            r_state   <= M_IDLE;
            r_mem_cyc <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        M_READ: begin
          if (mem_bus.ack) begin
            r_cpu_dat <= mem_bus.dat_r;
            r_cpu_ack <= 1'b1;
            r_state   <= M_IDLE;
            r_mem_cyc <= 1'b0;
          end
        end
        default: begin
          r_state   <= M_IDLE;
          r_mem_cyc <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_bus.cyc   = r_mem_cyc;
  assign mem_bus.stb   = r_mem_cyc;
  assign mem_bus.we    = r_mem_we;
  assign mem_bus.adr   = (r_state == M_WRITE) ? w_head_adr : cpu_bus.adr;
  assign mem_bus.dat_w = w_head_dat;
  assign cpu_bus.ack   = r_cpu_ack;
  assign cpu_bus.dat_r = r_cpu_dat;
  assign empty         = (w_count == '0) && (r_state == M_IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: CPU-side request tasks, a memory responder
// with selectable ACK behaviour, and a log of completed memory operations.
module tb_store_buffer;

  logic clk;
  logic rst_n;
  logic empty;

  wishbone #(.XLEN(32)) cpu_bus ();
  wishbone #(.XLEN(32)) mem_bus ();

  store_buffer #(.XLEN(32), .DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_bus (cpu_bus),
    .mem_bus (mem_bus),
    .empty   (empty)
  );

  int checks   = 0;
  int failures = 0;

  // 0: stall, 1: one-cycle ACK per access, 2: ACK every cycle STB is high
  int          ack_mode;
  logic [31:0] mem_rdata;
  logic [31:0] op_adr [64];
  logic [31:0] op_dat [64];
  logic        op_we  [64];
  int          n_ops = 0;

  assign mem_bus.dat_r = mem_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    mem_bus.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_bus.ack = 1'b0;
      end else if (mem_bus.cyc && mem_bus.stb &&
                   (ack_mode == 2 || (ack_mode == 1 && !mem_bus.ack))) begin
        mem_bus.ack = 1'b1;
        if (n_ops < 64) begin
          op_adr[n_ops] = mem_bus.adr;
          op_dat[n_ops] = mem_bus.dat_w;
          op_we[n_ops]  = mem_bus.we;
          n_ops++;
        end
      end else begin
        mem_bus.ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        output int lat);
    @(posedge clk); #1;
    cpu_bus.cyc   = 1'b1;
    cpu_bus.stb   = 1'b1;
    cpu_bus.we    = we;
    cpu_bus.adr   = adr;
    cpu_bus.dat_w = dat;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (cpu_bus.ack) begin
        lat = c;
        break;
      end
    end
    cpu_bus.cyc = 1'b0;
    cpu_bus.stb = 1'b0;
    cpu_bus.we  = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (empty) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, got, 1'b1);
  endtask

  initial begin
    int          lat;
    int          n0;
    logic        saw;
    logic [31:0] rd;

    rst_n         = 1'b0;
    ack_mode      = 1;
    mem_rdata     = 32'h0;
    cpu_bus.cyc   = 1'b0;
    cpu_bus.stb   = 1'b0;
    cpu_bus.we    = 1'b0;
    cpu_bus.adr   = '0;
    cpu_bus.dat_w = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_cyc", mem_bus.cyc, 1'b0);
    chk("rst_mem_we", mem_bus.we, 1'b0);
    chk("rst_cpu_ack", cpu_bus.ack, 1'b0);
    chk("rst_cpu_dat", cpu_bus.dat_r, 32'h0);
    chk("rst_empty", empty, 1'b1);
    rst_n = 1'b1;

    // single store then drain
    do_req(1'b1, 32'h100, 32'hDEADBEEF, lat);
    chk("st1_lat", lat, 1);
    wait_empty("st1_drain");
    chk("st1_nops", n_ops, 1);
    chk("st1_adr", op_adr[0], 32'h100);
    chk("st1_dat", op_dat[0], 32'hDEADBEEF);
    chk("st1_we", op_we[0], 1'b1);

    // fill to DEPTH with memory stalled, fifth store must wait for a pop
    ack_mode = 0;
    n0 = n_ops;
    for (int k = 0; k < 4; k++) begin
      do_req(1'b1, 32'(k * 4), 32'h1000 + 32'(k * 4), lat);
      chk("full_lat", lat, 1);
    end
    @(posedge clk); #1;
    cpu_bus.cyc   = 1'b1;
    cpu_bus.stb   = 1'b1;
    cpu_bus.we    = 1'b1;
    cpu_bus.adr   = 32'h10;
    cpu_bus.dat_w = 32'h1010;
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      saw = saw | cpu_bus.ack;
    end
    chk("full_no_ack", saw, 1'b0);
    ack_mode = 1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (cpu_bus.ack) begin
        lat = c;
        break;
      end
    end
    cpu_bus.cyc = 1'b0;
    cpu_bus.stb = 1'b0;
    cpu_bus.we  = 1'b0;
    chk("full_fifth_lat", lat, 2);
    wait_empty("full_drain");
    chk("full_nops", n_ops - n0, 5);
    for (int k = 0; k < 5; k++) begin
      chk("full_order_adr", op_adr[n0 + k], 32'(k * 4));
      chk("full_order_dat", op_dat[n0 + k], 32'h1000 + 32'(k * 4));
    end

    // forwarding from the youngest of two same-address stores
    ack_mode = 0;
    n0 = n_ops;
    do_req(1'b1, 32'h20, 32'h1, lat);
    do_req(1'b1, 32'h20, 32'h2, lat);
    do_req(1'b0, 32'h20, 32'h0, lat);
    chk("fwd_lat", lat, 1);
    chk("fwd_dat", cpu_bus.dat_r, 32'h2);
    @(posedge clk); #1;
    chk("fwd_hold_dat", cpu_bus.dat_r, 32'h2);
    chk("fwd_no_read", n_ops - n0, 0);
    chk("fwd_mem_we", mem_bus.we, 1'b1);
    ack_mode = 1;
    wait_empty("fwd_drain");
    chk("fwd_order0", op_dat[n0], 32'h1);
    chk("fwd_order1", op_dat[n0 + 1], 32'h2);

    // load miss waits for the drain, then reads memory
    mem_rdata = 32'hCAFEF00D;
    n0 = n_ops;
    do_req(1'b1, 32'h40, 32'h7, lat);
    do_req(1'b0, 32'h80, 32'h0, lat);
    chk("miss_got_ack", lat > 0, 1'b1);
    chk("miss_dat", cpu_bus.dat_r, 32'hCAFEF00D);
    chk("miss_nops", n_ops - n0, 2);
    chk("miss_first_we", op_we[n0], 1'b1);
    chk("miss_first_adr", op_adr[n0], 32'h40);
    chk("miss_second_we", op_we[n0 + 1], 1'b0);
    chk("miss_second_adr", op_adr[n0 + 1], 32'h80);
    wait_empty("miss_idle");

    // 2*DEPTH+1 stores with back-to-back memory ACKs, pointers wrap
    ack_mode = 2;
    n0 = n_ops;
    for (int k = 0; k < 9; k++) begin
      do_req(1'b1, 32'h200 + 32'(k * 4), 32'hA0 + 32'(k), lat);
      chk("wrap_lat", lat, 1);
    end
    wait_empty("wrap_drain");
    chk("wrap_nops", n_ops - n0, 9);
    for (int k = 0; k < 9; k++) begin
      chk("wrap_adr", op_adr[n0 + k], 32'h200 + 32'(k * 4));
      chk("wrap_dat", op_dat[n0 + k], 32'hA0 + 32'(k));
    end

    // youngest-match across physical wrap, leaves three stores buffered
    ack_mode = 0;
    do_req(1'b1, 32'h300, 32'hA, lat);
    do_req(1'b1, 32'h304, 32'hB, lat);
    do_req(1'b1, 32'h300, 32'hC, lat);
    do_req(1'b0, 32'h300, 32'h0, lat);
    chk("wfwd_lat", lat, 1);
    rd = cpu_bus.dat_r;
    chk("wfwd_young", rd, 32'hC);
    do_req(1'b0, 32'h304, 32'h0, lat);
    chk("wfwd_other", cpu_bus.dat_r, 32'hB);

    // reset mid-write with three entries queued
    n0 = n_ops;
    chk("rstw_cyc_before", mem_bus.cyc, 1'b1);
    chk("rstw_we_before", mem_bus.we, 1'b1);
    chk("rstw_empty_before", empty, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_cyc", mem_bus.cyc, 1'b0);
    chk("rstw_empty", empty, 1'b1);
    chk("rstw_cpu_ack", cpu_bus.ack, 1'b0);
    chk("rstw_cpu_dat", cpu_bus.dat_r, 32'h0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    ack_mode = 1;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      saw = saw | cpu_bus.ack | mem_bus.cyc | mem_bus.ack;
    end
    chk("rstw_quiet", saw, 1'b0);
    chk("rstw_no_ops", n_ops - n0, 0);
    chk("rstw_empty_after", empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
